uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ   = 25_000_000;
    localparam int unsigned DEF_BAUD_RATE  = 115_200;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through FIFO for received bytes.
// A push that meets a full FIFO is dropped unless a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            pop_ok;
    logic            push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO, with sticky overrun/framing flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart,
    input  logic       i_read_flag,
    input  logic       i_clear,
    output logic [7:0] o_bin,
    output logic       o_valid,
    output logic       o_full,
    output logic       o_overrun,
    output logic       o_frame_err
);

    localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF = CPB / 2;
    localparam int          CW   = $clog2(CPB);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic          push_q, push_nxt;
    logic          ferr_set;

    logic sync1, sync2, sync3;
    logic rx_bit, fall;

    logic empty, fifo_drop;

    // Line is asynchronous; only sync2 onward is used, sync3 gives the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= i_uart;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_bit = sync2;
    assign fall   = sync3 & ~sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            push_q  <= push_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        push_nxt  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_bit ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_bit, shreg[7:1]};
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_bit) push_nxt = 1'b1;
                    else        ferr_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The receiver never looks at FIFO state; a full FIFO only costs the byte.
    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_q),
        .pop   (i_read_flag),
        .wdata (shreg),
        .rdata (o_bin),
        .full  (o_full),
        .empty (empty),
        .drop  (fifo_drop)
    );

    assign o_valid = ~empty;

    // Clear loses to a coincident set event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (fifo_drop)    o_overrun <= 1'b1;
            else if (i_clear) o_overrun <= 1'b0;
            if (ferr_set)     o_frame_err <= 1'b1;
            else if (i_clear) o_frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_uart_rx_fifo;

    localparam int CPB      = 217;
    localparam int HALF     = 108;
    localparam int DEPTH    = 4;
    // Start bit launched just after edge P0: line seen through 2 sync flops,
    // edge detected, half bit, 8 data bits and the stop bit, push one cycle later.
    localparam int LAT_ERR  = 3 + HALF + 9 * CPB;
    localparam int LAT_PUSH = LAT_ERR + 1;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_uart = 1'b1;
    logic       i_read_flag = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] o_bin;
    logic       o_valid, o_full, o_overrun, o_frame_err;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(
        .CLK_FREQ   (25_000_000),
        .BAUD_RATE  (115_200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_uart      (i_uart),
        .i_read_flag (i_read_flag),
        .i_clear     (i_clear),
        .o_bin       (o_bin),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    always #20 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         edge_no;
        bit         is_push;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    int         edge_n = 0;
    bit         pop_now, push_now, ovr_set, ferr_set;
    logic [7:0] pb;

    always @(posedge i_clk) begin
        edge_n++;
        if (!i_rst_n) begin
            mq.delete();
            evq.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            pop_now  = i_read_flag && (mq.size() > 0);
            push_now = 1'b0;
            ovr_set  = 1'b0;
            ferr_set = 1'b0;
            pb       = 8'h00;
            for (int k = evq.size() - 1; k >= 0; k--) begin
                if (evq[k].edge_no == edge_n) begin
                    if (evq[k].is_push) begin
                        push_now = 1'b1;
                        pb       = evq[k].b;
                    end else begin
                        ferr_set = 1'b1;
                    end
                    evq.delete(k);
                end
            end
            if (pop_now) void'(mq.pop_front());
            if (push_now) begin
                if (mq.size() < DEPTH) mq.push_back(pb);
                else                   ovr_set = 1'b1;
            end
            if (i_clear) begin
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
            if (ovr_set)  m_ovr  = 1'b1;
            if (ferr_set) m_ferr = 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            logic        e_valid;
            logic [11:0] act, exp;
            e_valid = (mq.size() > 0);
            exp = {e_valid, (mq.size() == DEPTH), m_ovr, m_ferr, e_valid ? mq[0] : 8'h00};
            act = {o_valid, o_full, o_overrun, o_frame_err, e_valid ? o_bin : 8'h00};
            check("model{valid,full,ovr,ferr,bin}", 32'(act), 32'(exp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        int p0;
        ev_t e;
        @(posedge i_clk); #1;
        p0 = edge_n;
        e.is_push = stop_bit;
        e.b       = b;
        e.edge_no = p0 + (stop_bit ? LAT_PUSH : LAT_ERR);
        evq.push_back(e);
        i_uart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge i_clk); #1;
            i_uart = b[i];
        end
        repeat (CPB) @(posedge i_clk); #1;
        i_uart = stop_bit;
        repeat (CPB) @(posedge i_clk); #1;
        i_uart = 1'b1;
        repeat (20) @(posedge i_clk); #1;
    endtask

    task automatic pop_byte(input string name, input logic [7:0] exp_b);
        check({name, ".valid"}, 32'(o_valid), 32'd1);
        check({name, ".bin"}, 32'(o_bin), 32'(exp_b));
        i_read_flag = 1'b1;
        @(posedge i_clk); #1;
        i_read_flag = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_clear = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".valid"}, 32'(o_valid), 32'd0);
        check({name, ".full"},  32'(o_full),  32'd0);
        check({name, ".bin"},   32'(o_bin),   32'h00);
        check({name, ".ovr"},   32'(o_overrun),   32'd0);
        check({name, ".ferr"},  32'(o_frame_err), 32'd0);
    endtask

    initial begin
        #5;
        check_reset_state("reset");
        repeat (3) @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (10) @(posedge i_clk); #1;

        // Single byte, no pop until checked.
        send_frame(8'hA5, 1'b1);
        check("a5.ovr", 32'(o_overrun), 32'd0);
        check("a5.ferr", 32'(o_frame_err), 32'd0);
        pop_byte("a5", 8'hA5);
        check("a5.after_pop", 32'(o_valid), 32'd0);

        // Fill past depth.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("fill4.full", 32'(o_full), 32'd1);
        check("fill4.ovr", 32'(o_overrun), 32'd0);
        send_frame(8'h05, 1'b1);
        check("fill5.ovr", 32'(o_overrun), 32'd1);
        pop_byte("p01", 8'h01);
        check("p01.full", 32'(o_full), 32'd0);
        pop_byte("p02", 8'h02);
        pop_byte("p03", 8'h03);
        pop_byte("p04", 8'h04);
        check("drain.valid", 32'(o_valid), 32'd0);
        i_read_flag = 1'b1;
        @(posedge i_clk); #1;
        i_read_flag = 1'b0;
        check("empty_pop.valid", 32'(o_valid), 32'd0);
        pulse_clear();
        check("clr.ovr", 32'(o_overrun), 32'd0);

        // Framing error.
        send_frame(8'h3C, 1'b0);
        check("ferr.flag", 32'(o_frame_err), 32'd1);
        check("ferr.valid", 32'(o_valid), 32'd0);
        pulse_clear();
        check("ferr.clr", 32'(o_frame_err), 32'd0);

        // Short glitch on idle line.
        i_uart = 1'b0;
        repeat (50) @(posedge i_clk); #1;
        i_uart = 1'b1;
        repeat (300) @(posedge i_clk); #1;
        check("glitch.valid", 32'(o_valid), 32'd0);
        check("glitch.ovr", 32'(o_overrun), 32'd0);
        check("glitch.ferr", 32'(o_frame_err), 32'd0);

        // Full FIFO, pop exactly in the push cycle of 8'h77.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        check("pp.pre_full", 32'(o_full), 32'd1);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (LAT_PUSH) @(posedge i_clk); #1;
                i_read_flag = 1'b1;
                @(posedge i_clk); #1;
                i_read_flag = 1'b0;
            end
        join
        check("pp.full", 32'(o_full), 32'd1);
        check("pp.ovr", 32'(o_overrun), 32'd0);
        pop_byte("pp22", 8'h22);
        pop_byte("pp33", 8'h33);
        pop_byte("pp44", 8'h44);
        pop_byte("pp77", 8'h77);
        check("pp.drain", 32'(o_valid), 32'd0);

        // Reset in the middle of 8'hFF's data bits.
        @(posedge i_clk); #1;
        i_uart = 1'b0;
        repeat (CPB) @(posedge i_clk); #1;
        i_uart = 1'b1;
        repeat (3 * CPB) @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #2;
        check_reset_state("midrst");
        repeat (5) @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (2 * CPB) @(posedge i_clk); #1;
        check("midrst.valid", 32'(o_valid), 32'd0);
        send_frame(8'h5A, 1'b1);
        check("5a.ovr", 32'(o_overrun), 32'd0);
        check("5a.ferr", 32'(o_frame_err), 32'd0);
        pop_byte("5a", 8'h5A);
        check("5a.only", 32'(o_valid), 32'd0);

        repeat (5) @(posedge i_clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
